// File: rtl/tristate_conduit_timed_bridge.sv
// Avalon-MM slave to tristate conduit bridge with programmable setup/strobe/hold/turnaround timing.
// Optional macro TCB_READY_EN adds a synchronised flash ready input that stretches the strobe phase.
module tristate_conduit_timed_bridge #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 2,
    parameter int WAIT_CYC  = 6,
    parameter int HOLD_CYC  = 2,
    parameter int TURN_CYC  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef TCB_READY_EN
    input  logic              tcm_ready_in,
`endif
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] tcm_address_out,
    output logic              tcm_chipselect_n_out,
    output logic              tcm_read_n_out,
    output logic              tcm_write_n_out,
    inout  wire  [DATA_W-1:0] tcm_data_out
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, TURN} state_t;

    // Counters are loaded with (cycles - 1) and the phase ends when they read zero.
    localparam logic [7:0] SETUP_LD = (SETUP_CYC > 0) ? 8'(SETUP_CYC - 1) : 8'd0;
    localparam logic [7:0] WAIT_LD  = (WAIT_CYC  > 0) ? 8'(WAIT_CYC  - 1) : 8'd0;
    localparam logic [7:0] HOLD_LD  = (HOLD_CYC  > 0) ? 8'(HOLD_CYC  - 1) : 8'd0;
    localparam logic [7:0] TURN_LD  = (TURN_CYC  > 0) ? 8'(TURN_CYC  - 1) : 8'd0;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cs_n_q, rd_n_q, wr_n_q, drive_q, wait_q, rdv_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept, access_done, read_done, busy_d, access_ready;
    state_t            post_hold_state;
    logic [7:0]        post_hold_cnt;

`ifdef TCB_READY_EN
    logic [1:0] ready_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_sync <= 2'b00;
        end else begin
            ready_sync <= {ready_sync[0], tcm_ready_in};
        end
    end

    assign access_ready = ready_sync[1];
`else
    assign access_ready = 1'b1;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        write_d         = write_q;
        accept          = 1'b0;
        access_done     = (state_q == ACCESS) && (cnt_q == 8'd0) && access_ready;
        post_hold_state = IDLE;
        post_hold_cnt   = 8'd0;
        if (!write_q && TURN_CYC != 0) begin
            post_hold_state = TURN;
            post_hold_cnt   = TURN_LD;
        end

        case (state_q)
            IDLE: begin
                if (avs_read || avs_write) begin
                    accept  = 1'b1;
                    write_d = avs_write;
                    if (SETUP_CYC != 0) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACCESS: begin
                if (access_done) begin
                    if (HOLD_CYC != 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = post_hold_state;
                        cnt_d   = post_hold_cnt;
                    end
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = post_hold_state;
                    cnt_d   = post_hold_cnt;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            TURN: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d    = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
    assign read_done = access_done && !write_q;

    // NOTE: pin outputs are registered from the next state rather than decoded from the state register, so strobes never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            drive_q <= 1'b0;
            wait_q  <= 1'b0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            if (accept) begin
                addr_q  <= avs_address;
                wdata_q <= avs_writedata;
            end
            cs_n_q  <= !busy_d;
            rd_n_q  <= !((state_d == ACCESS) && !write_d);
            wr_n_q  <= !((state_d == ACCESS) && write_d);
            drive_q <= busy_d && write_d;
            wait_q  <= (state_d != IDLE);
            rdv_q   <= read_done;
            if (read_done) begin
                rdata_q <= tcm_data_out;
            end
        end
    end

    assign tcm_data_out         = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign tcm_address_out      = addr_q;
    assign tcm_chipselect_n_out = cs_n_q;
    assign tcm_read_n_out       = rd_n_q;
    assign tcm_write_n_out      = wr_n_q;
    assign avs_waitrequest      = wait_q;
    assign avs_readdatavalid    = rdv_q;
    assign avs_readdata         = rdata_q;

endmodule

// File: tb/tb_tristate_conduit_timed_bridge.sv
// Directed bench: default-timing bridge (a_*) plus a minimum-timing bridge (b_*), each with a simple memory model.
// Status vectors are {chipselect_n, read_n, write_n, readdatavalid, waitrequest}.
module tb_tristate_conduit_timed_bridge;

    localparam int AW = 27;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ready = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] a_address, b_address;
    logic          a_read, a_write, b_read, b_write;
    logic [DW-1:0] a_writedata, b_writedata, a_readdata, b_readdata;
    logic          a_rdv, a_wait, b_rdv, b_wait;
    logic [AW-1:0] a_tcm_addr, b_tcm_addr;
    logic          a_cs_n, a_rd_n, a_wr_n, b_cs_n, b_rd_n, b_wr_n;
    wire  [DW-1:0] a_bus, b_bus;

    // Memory models drive their read word while chip select and output enable are both low.
    assign a_bus = (!a_cs_n && !a_rd_n) ? 16'hBEEF : {DW{1'bz}};
    assign b_bus = (!b_cs_n && !b_rd_n) ? 16'hC3A5 : {DW{1'bz}};

    int n_checks = 0;
    int n_fail   = 0;

    tristate_conduit_timed_bridge dut_a (
        .clk                  (clk),
        .reset_n              (reset_n),
`ifdef TCB_READY_EN
        .tcm_ready_in         (ready),
`endif
        .avs_address          (a_address),
        .avs_read             (a_read),
        .avs_write            (a_write),
        .avs_writedata        (a_writedata),
        .avs_readdata         (a_readdata),
        .avs_readdatavalid    (a_rdv),
        .avs_waitrequest      (a_wait),
        .tcm_address_out      (a_tcm_addr),
        .tcm_chipselect_n_out (a_cs_n),
        .tcm_read_n_out       (a_rd_n),
        .tcm_write_n_out      (a_wr_n),
        .tcm_data_out         (a_bus)
    );

    tristate_conduit_timed_bridge #(
        .SETUP_CYC (0),
        .WAIT_CYC  (1),
        .HOLD_CYC  (0),
        .TURN_CYC  (0)
    ) dut_b (
        .clk                  (clk),
        .reset_n              (reset_n),
`ifdef TCB_READY_EN
        .tcm_ready_in         (ready),
`endif
        .avs_address          (b_address),
        .avs_read             (b_read),
        .avs_write            (b_write),
        .avs_writedata        (b_writedata),
        .avs_readdata         (b_readdata),
        .avs_readdatavalid    (b_rdv),
        .avs_waitrequest      (b_wait),
        .tcm_address_out      (b_tcm_addr),
        .tcm_chipselect_n_out (b_cs_n),
        .tcm_read_n_out       (b_rd_n),
        .tcm_write_n_out      (b_wr_n),
        .tcm_data_out         (b_bus)
    );

    // Presents a command on bridge A during cycle 0; returns just after the accepting edge.
    task automatic issue_a(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        @(negedge clk);
        a_read      = rd;
        a_write     = wr;
        a_address   = addr;
        a_writedata = wd;
        @(posedge clk);
        #1;
        a_read  = 1'b0;
        a_write = 1'b0;
    endtask

    task automatic test_reset;
        logic [4:0] st;
        #2;
        st = {a_cs_n, a_rd_n, a_wr_n, a_rdv, a_wait};
        n_checks++;
        if (st !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected %b", st, 5'b11100);
        end
        n_checks++;
        if (a_readdata !== 16'h0000 || a_tcm_addr !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_data_addr: got rdata %h addr %h expected 0/0", a_readdata, a_tcm_addr);
        end
        n_checks++;
        if (a_bus === 16'hBEEF) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected released bus", a_bus);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_read;
        logic [4:0] st, ex;
        issue_a(1'b1, 1'b0, 27'h0001234, 16'h0000);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            st = {a_cs_n, a_rd_n, a_wr_n, a_rdv, a_wait};
            ex = {!(k <= 10), !(k >= 3 && k <= 8), 1'b1, (k == 9), (k <= 11)};
            n_checks++;
            if (st !== ex) begin
                n_fail++;
                $display("FAIL read_status cycle %0d: got %b expected %b", k, st, ex);
            end
            if (k == 1) begin
                n_checks++;
                if (a_tcm_addr !== 27'h0001234) begin
                    n_fail++;
                    $display("FAIL read_addr: got %h expected %h", a_tcm_addr, 27'h0001234);
                end
            end
            if (k == 9) begin
                n_checks++;
                if (a_readdata !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", a_readdata, 16'hBEEF);
                end
            end
        end
    endtask

    // Shared by the plain write and the read+write collision: both must look like a pure write.
    task automatic run_write(input logic with_read, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        logic [4:0] st, ex;
        issue_a(with_read, 1'b1, addr, wd);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            st = {a_cs_n, a_rd_n, a_wr_n, a_rdv, a_wait};
            ex = {!(k <= 10), 1'b1, !(k >= 3 && k <= 8), 1'b0, (k <= 10)};
            n_checks++;
            if (st !== ex) begin
                n_fail++;
                $display("FAIL write_status rd=%0b cycle %0d: got %b expected %b", with_read, k, st, ex);
            end
            if (k <= 10) begin
                n_checks++;
                if (a_bus !== wd) begin
                    n_fail++;
                    $display("FAIL write_bus cycle %0d: got %h expected %h", k, a_bus, wd);
                end
            end else if (k == 11) begin
                n_checks++;
                if (a_bus === wd) begin
                    n_fail++;
                    $display("FAIL write_release cycle 11: got %h expected released bus", a_bus);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (a_tcm_addr !== addr) begin
                    n_fail++;
                    $display("FAIL write_addr: got %h expected %h", a_tcm_addr, addr);
                end
            end
        end
    endtask

    task automatic test_write;
        run_write(1'b0, 27'h7FFFFFF, 16'h5A5A);
    endtask

    task automatic test_read_write_collision;
        run_write(1'b1, 27'h0000010, 16'h0F0F);
    endtask

    task automatic test_fast_read;
        logic [4:0] st, ex;
        @(negedge clk);
        b_read    = 1'b1;
        b_address = 27'h0000ABC;
        @(posedge clk);
        #1;
        b_read = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            st = {b_cs_n, b_rd_n, b_wr_n, b_rdv, b_wait};
            ex = {!(k == 1 || k == 3), !(k == 1 || k == 3), 1'b1, (k == 2 || k == 4), (k == 1 || k == 3)};
            n_checks++;
            if (st !== ex) begin
                n_fail++;
                $display("FAIL fast_status cycle %0d: got %b expected %b", k, st, ex);
            end
            if (k == 2) begin
                n_checks++;
                if (b_readdata !== 16'hC3A5) begin
                    n_fail++;
                    $display("FAIL fast_data: got %h expected %h", b_readdata, 16'hC3A5);
                end
                b_read    = 1'b1;
                b_address = 27'h0000ABD;
                @(posedge clk);
                #1;
                b_read = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [4:0] st;
        issue_a(1'b1, 1'b0, 27'h0000222, 16'h0000);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        st = {a_cs_n, a_rd_n, a_wr_n, a_rdv, a_wait};
        n_checks++;
        if (st !== 5'b11100) begin
            n_fail++;
            $display("FAIL midread_reset_status: got %b expected %b", st, 5'b11100);
        end
        n_checks++;
        if (a_readdata !== 16'h0000 || a_tcm_addr !== 27'h0) begin
            n_fail++;
            $display("FAIL midread_reset_regs: got rdata %h addr %h expected 0/0", a_readdata, a_tcm_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_rdv !== 1'b0 || a_wait !== 1'b0) begin
                n_fail++;
                $display("FAIL midread_after_release cycle %0d: got rdv %b wait %b expected 0/0", k, a_rdv, a_wait);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        issue_a(1'b0, 1'b1, 27'h0000055, 16'h6C6C);
        repeat (5) @(negedge clk);
        n_checks++;
        if (a_bus !== 16'h6C6C) begin
            n_fail++;
            $display("FAIL midwrite_bus: got %h expected %h", a_bus, 16'h6C6C);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (a_bus === 16'h6C6C || a_wr_n !== 1'b1 || a_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL midwrite_reset: got bus %h wr_n %b cs_n %b expected released/1/1", a_bus, a_wr_n, a_cs_n);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

`ifdef TCB_READY_EN
    task automatic test_ready;
        logic [4:0] st, ex;
        ready = 1'b0;
        issue_a(1'b1, 1'b0, 27'h0000777, 16'h0000);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            st = {a_cs_n, a_rd_n, a_wr_n, a_rdv, a_wait};
            ex = {!(k <= 18), !(k >= 3 && k <= 16), 1'b1, (k == 17), (k <= 19)};
            n_checks++;
            if (st !== ex) begin
                n_fail++;
                $display("FAIL ready_status cycle %0d: got %b expected %b", k, st, ex);
            end
            if (k == 17) begin
                n_checks++;
                if (a_readdata !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL ready_data: got %h expected %h", a_readdata, 16'hBEEF);
                end
            end
            if (k == 13) begin
                @(posedge clk);
                #1;
                ready = 1'b1;
            end
        end
    endtask
`endif

    initial begin
        a_address = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
        repeat (3) @(posedge clk);
        test_reset;
        repeat (2) @(negedge clk);
        test_read;
        test_write;
        test_read_write_collision;
        test_fast_read;
        test_reset_mid_read;
        test_read;
        test_reset_mid_write;
`ifdef TCB_READY_EN
        test_ready;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
